countdown_scheduler: RTL and testbench

- Shares one down-counter datapath between NUM_REQ requesters.
- Each requester asks for a countdown of a given length. A round-robin arbiter grants the counter, the FSM sequences load/count/done, and the block reports completion with the winning requester's ID.
- Also exports the live count and a registered 2*count value. This is the datapath the counter testbenches already check.
- Sits between timer clients and the shared counter, as its sequencer.

---
 rtl/countdown_sched_pkg.sv | 13 +
 rtl/countdown_scheduler_rr_arbiter.sv | 36 +++
 rtl/countdown_scheduler.sv | 116 +++++++++++
 tb/tb_countdown_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_sched_pkg.sv
// Shared types and defaults for the countdown scheduler: FSM state encoding
// and the default counter width.
package countdown_sched_pkg;

  localparam int CNT_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/countdown_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after
// last_grant (wrapping), returning both a one-hot grant and its index.
module rr_arbiter
  import countdown_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (enable) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (int'(last_grant) + k) % NUM_REQ;
        if (!found && req[idx]) begin
          found          = 1'b1;
          grant[idx]     = 1'b1;
          grant_idx      = ID_W'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/countdown_scheduler.sv
// Sequencer that lends one shared down-counter to NUM_REQ timer clients in
// round-robin order and reports which client's countdown completed.
//
//   state | meaning
//   IDLE  | counter free; req_ready offered to the round-robin winner
//   COUNT | counting down the granted length (pause freezes, abort cancels)
//   DONE  | single-cycle completion pulse for grant_id
module countdown_scheduler
  import countdown_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*CNT_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     pause,
  input  logic                     abort,
  output logic                     busy,
  output logic [ID_W-1:0]          grant_id,
  output logic [CNT_W-1:0]         count,
  output logic [CNT_W:0]           double_count,
  output logic                     done_valid,
  output logic [ID_W-1:0]          done_id
);

  sched_state_t     state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W:0]   dbl_q, dbl_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  last_q, last_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic [CNT_W-1:0]   sel_len;
  logic               accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_q),
    .enable     (state_q == IDLE),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  assign accept  = |arb_grant;
  assign sel_len = req_len[int'(arb_idx)*CNT_W +: CNT_W];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    grant_d = grant_q;
    last_d  = last_q;
    dbl_d   = {1'b0, count_q} << 1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          grant_d = arb_idx;
          last_d  = arb_idx;
          count_d = sel_len;
          // A zero-length job has nothing to count, so it completes directly.
          state_d = (sel_len != '0) ? COUNT : DONE;
        end
      end
      COUNT: begin
        if (abort) begin
          state_d = IDLE;
          count_d = '0;
        end else if (!pause) begin
          count_d = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      count_q <= '0;
      dbl_q   <= '0;
      grant_q <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dbl_q   <= dbl_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign req_ready    = arb_grant;
  assign busy         = (state_q == COUNT) || (state_q == DONE);
  assign grant_id     = grant_q;
  assign count        = count_q;
  assign double_count = dbl_q;
  assign done_valid   = (state_q == DONE);
  assign done_id      = (state_q == DONE) ? grant_q : '0;

endmodule

// File: tb/tb_countdown_scheduler.sv
// Self-checking bench for countdown_scheduler: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a job model.
module tb_countdown_scheduler;

  localparam int NR = 4;
  localparam int CW = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_b = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*CW-1:0] req_len = '0;
  logic [NR-1:0]   req_ready;
  logic            pause = 1'b0;
  logic            abort = 1'b0;
  logic            busy;
  logic [IW-1:0]   grant_id;
  logic [CW-1:0]   count;
  logic [CW:0]     double_count;
  logic            done_valid;
  logic [IW-1:0]   done_id;

  countdown_scheduler #(.NUM_REQ(NR), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .req_valid    (req_valid),
    .req_len      (req_len),
    .req_ready    (req_ready),
    .pause        (pause),
    .abort        (abort),
    .busy         (busy),
    .grant_id     (grant_id),
    .count        (count),
    .double_count (double_count),
    .done_valid   (done_valid),
    .done_id      (done_id)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Job-level model: a counting job with remaining length, a pending
  // completion, the owner and the last-granted requester.
  int  m_cnt, m_dbl, m_owner, m_last, acc_id;
  bit  m_counting, m_done;
  logic [NR-1:0] exp_ready;

  function automatic void chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_dbl = 0; m_owner = 0; m_last = NR - 1; acc_id = -1;
    m_counting = 1'b0; m_done = 1'b0;
  endtask

  // Compare at the falling edge, advance the model, return #1 after the rising edge.
  task automatic step();
    int idx, n_dbl;
    @(negedge clk);
    exp_ready = '0;
    acc_id = -1;
    if (!m_counting && !m_done) begin
      for (int k = 1; k <= NR; k++) begin
        idx = (m_last + k) % NR;
        if (acc_id < 0 && req_valid[idx]) begin
          acc_id = idx;
          exp_ready[idx] = 1'b1;
        end
      end
    end
    chk("req_ready", int'(req_ready), int'(exp_ready));
    chk("busy", int'(busy), int'(m_counting || m_done));
    chk("grant_id", int'(grant_id), m_owner);
    chk("count", int'(count), m_cnt);
    chk("double_count", int'(double_count), m_dbl);
    chk("done_valid", int'(done_valid), int'(m_done));
    chk("done_id", int'(done_id), m_done ? m_owner : 0);
    n_dbl = 2 * m_cnt;
    if (m_done) begin
      m_done = 1'b0;
    end else if (m_counting) begin
      if (abort) begin
        m_counting = 1'b0;
        m_cnt = 0;
      end else if (!pause) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_counting = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (acc_id >= 0) begin
      m_owner = acc_id;
      m_last = acc_id;
      m_cnt = int'(req_len[acc_id*CW +: CW]);
      if (m_cnt == 0) m_done = 1'b1;
      else m_counting = 1'b1;
    end
    m_dbl = n_dbl;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_b = 1'b0;
    req_valid = '0; req_len = '0; pause = 1'b0; abort = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_b = 1'b1;
  endtask

  task automatic drive_random();
    for (int i = 0; i < NR; i++) begin
      if (acc_id == i) req_valid[i] = 1'b0;
      else if (req_valid[i] && $urandom_range(15) == 0) req_valid[i] = 1'b0;
      if (!req_valid[i] && $urandom_range(2) == 0) begin
        req_valid[i] = 1'b1;
        req_len[i*CW +: CW] = ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom_range(15));
      end
    end
    pause = ($urandom_range(3) == 0);
    abort = ($urandom_range(19) == 0);
  endtask

  int g[8];
  int s[8];
  int ng, done_at;

  initial begin
    // Reset values
    reset_dut();
    chk("rst_count", int'(count), 0);
    chk("rst_dbl", int'(double_count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_grant", int'(grant_id), 0);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_done", int'(done_valid), 0);

    // Single request of length 15
    req_valid = 4'b0001; req_len = 16'h000F;
    step();
    chk("t1_acc", acc_id, 0);
    req_valid = '0;
    chk("t1_cnt0", int'(count), 15); chk("t1_dbl0", int'(double_count), 0);
    step(); chk("t1_cnt1", int'(count), 14); chk("t1_dbl1", int'(double_count), 30);
    step(); chk("t1_cnt2", int'(count), 13); chk("t1_dbl2", int'(double_count), 28);
    step(); chk("t1_cnt3", int'(count), 12); chk("t1_dbl3", int'(double_count), 26);
    step(); chk("t1_cnt4", int'(count), 11); chk("t1_dbl4", int'(double_count), 24);
    done_at = -1;
    for (int j = 5; j <= 40 && done_at < 0; j++) begin
      step();
      if (done_valid) done_at = j;
    end
    chk("t1_done_edge", done_at, 15);
    chk("t1_done_id", int'(done_id), 0);
    chk("t1_done_cnt", int'(count), 0);

    // Round-robin with all four requesters holding len=2
    reset_dut();
    req_valid = 4'b1111; req_len = 16'h2222;
    ng = 0;
    for (int j = 0; j < 25; j++) begin
      step();
      if (acc_id >= 0 && ng < 8) begin
        g[ng] = int'(grant_id);
        s[ng] = j;
        ng++;
      end
    end
    req_valid = '0;
    chk("t2_grants_seen", (ng >= 5) ? 1 : 0, 1);
    if (ng >= 5) begin
      chk("t2_g0", g[0], 0); chk("t2_g1", g[1], 1); chk("t2_g2", g[2], 2);
      chk("t2_g3", g[3], 3); chk("t2_g4", g[4], 0);
      // accept cycle, two count cycles, done cycle -> next accept 4 edges later
      chk("t2_spacing", s[1] - s[0], 4);
      chk("t2_spacing4", s[4] - s[3], 4);
    end
    step();

    // Zero-length request
    reset_dut();
    req_valid = 4'b0100; req_len = 16'h0000;
    step();
    chk("t3_acc", acc_id, 2);
    req_valid = '0;
    chk("t3_done", int'(done_valid), 1);
    chk("t3_done_id", int'(done_id), 2);
    chk("t3_count", int'(count), 0);
    step();
    chk("t3_done_gone", int'(done_valid), 0);
    chk("t3_idle", int'(busy), 0);

    // Pause for three cycles at count 3
    reset_dut();
    req_valid = 4'b0001; req_len = 16'h0005;
    step(); req_valid = '0; chk("t4_c5", int'(count), 5);
    step(); chk("t4_c4", int'(count), 4);
    step(); chk("t4_c3", int'(count), 3);
    pause = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step(); chk("t4_hold", int'(count), 3);
    end
    pause = 1'b0;
    step(); chk("t4_c2", int'(count), 2);
    step(); chk("t4_c1", int'(count), 1); chk("t4_nodone", int'(done_valid), 0);
    step(); chk("t4_c0", int'(count), 0); chk("t4_done", int'(done_valid), 1);
    step();

    // Abort at count 6
    reset_dut();
    req_valid = 4'b0010; req_len = 16'h00A0;
    step(); chk("t5_acc", acc_id, 1);
    req_valid = '0;
    repeat (4) step();
    chk("t5_c6", int'(count), 6);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_count", int'(count), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_nodone", int'(done_valid), 0);
    req_valid = 4'b1111; req_len = 16'h3333;
    #1;
    chk("t5_next_ready", int'(req_ready), 4);
    step();
    req_valid = '0;
    repeat (6) step();

    // Reset while count is 7
    reset_dut();
    req_valid = 4'b0001; req_len = 16'h000C;
    step(); req_valid = '0;
    repeat (5) step();
    chk("t6_c7", int'(count), 7);
    chk("t6_d7", int'(double_count), 16);
    rst_b = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_cnt", int'(count), 0);
    chk("t6_rst_dbl", int'(double_count), 0);
    chk("t6_rst_done", int'(done_valid), 0);
    chk("t6_rst_busy", int'(busy), 0);
    #1;
    rst_b = 1'b1;
    req_valid = 4'b0011; req_len = 16'h0094;
    #1;
    chk("t6_prio", int'(req_ready), 1);
    step();
    req_valid = '0;
    chk("t6_restart", int'(count), 4);
    repeat (6) step();

    // Randomized traffic with occasional asynchronous resets
    reset_dut();
    for (int j = 0; j < 3000; j++) begin
      step();
      if ($urandom_range(399) == 0) begin
        rst_b = 1'b0;
        model_reset();
        #1;
        rst_b = 1'b1;
      end
      drive_random();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
